matrix_mult_seq: RTL and testbench

MATRIX_MULT_SEQ -- requirements
Module: matrix_mult_seq

---
 rtl/matrix_mult_seq.sv | 112 +++++++++++
 tb/tb_matrix_mult_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential NxN unsigned matrix multiply, one multiply-accumulate per cycle.
// Define MATRIX_MULT_SAT_EN for full-width products and results clamped to 2^W-1.
module matrix_mult_seq #(
   parameter int N = 3,
   parameter int W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N*N*W-1:0] A,
   input  logic [N*N*W-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [N*N*W-1:0] Result
);
   localparam int IW = $clog2(N);
`ifdef MATRIX_MULT_SAT_EN
   localparam int PW = 2*W;
   localparam int AW = 2*W + $clog2(N);
`else
   localparam int PW = W;
   localparam int AW = W;
`endif
   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
   state_t state;
   logic [W-1:0] a_m [N][N];
   logic [W-1:0] b_m [N][N];
   logic [W-1:0] c_m [N][N];
   logic [W-1:0] c_nx [N][N];
   logic [AW-1:0] acc, sum;
   logic [PW-1:0] prod;
   logic [W-1:0] elem;
   logic [IW-1:0] i, j, k;
   logic last_k, last_j, last_i;
   always_comb begin
      last_k = k == IW'(N-1);
      last_j = j == IW'(N-1);
      last_i = i == IW'(N-1);
      prod = PW'(a_m[i][k]) * PW'(b_m[k][j]);
      sum = acc + AW'(prod);
`ifdef MATRIX_MULT_SAT_EN
      elem = (sum > AW'({W{1'b1}})) ? {W{1'b1}} : sum[W-1:0];
`else
      elem = sum[W-1:0];
`endif
      c_nx = c_m;
      if (state == MAC && last_k) c_nx[i][j] = elem;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         Result <= '0;
         acc <= '0;
         i <= '0;
         j <= '0;
         k <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  for (int r = 0; r < N; r++)
                     for (int c = 0; c < N; c++) begin
                        a_m[r][c] <= A[(N*N-1-(r*N+c))*W +: W];
                        b_m[r][c] <= B[(N*N-1-(r*N+c))*W +: W];
                     end
                  acc <= '0;
                  i <= '0;
                  j <= '0;
                  k <= '0;
                  busy <= 1'b1;
                  state <= MAC;
               end
            end
            MAC: begin
               c_m <= c_nx;
               if (last_k) begin
                  acc <= '0;
                  k <= '0;
                  if (last_j) begin
                     j <= '0;
                     if (last_i) begin
                        i <= '0;
                        busy <= 1'b0;
                        done <= 1'b1;
                        state <= DONE;
                        // c_nx already includes the final element written this cycle
                        for (int r = 0; r < N; r++)
                           for (int c = 0; c < N; c++)
                              Result[(N*N-1-(r*N+c))*W +: W] <= c_nx[r][c];
                     end else begin
                        i <= i + 1'b1;
                     end
                  end else begin
                     j <= j + 1'b1;
                  end
               end else begin
                  acc <= sum;
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               done <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb_matrix_mult_seq: table vectors, corner sequences and random operands checked against a matrix model.
module tb_matrix_mult_seq;
   logic clk = 0, rst = 1, start = 0, start2 = 0;
   logic [143:0] A = '0, B = '0, Result;
   logic [31:0] A2 = '0, B2 = '0, res2;
   logic busy, done, busy2, done2;
   int n_chk = 0, n_fail = 0;

   matrix_mult_seq #(.N(3), .W(16)) dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .Result(Result));
   matrix_mult_seq #(.N(2), .W(8)) dut2 (.clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2),
      .busy(busy2), .done(done2), .Result(res2));

   always #5 clk = ~clk;

   typedef struct {
      logic [143:0] a;
      logic [143:0] b;
      logic [143:0] exp;
      string nm;
   } vec_t;
   vec_t tv[3];

   task automatic check(input string nm, input logic [143:0] act, input logic [143:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [143:0] model(input logic [143:0] a, input logic [143:0] b);
      logic [143:0] r = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            longint s = 0;
            for (int k = 0; k < 3; k++) begin
               longint p = longint'(a[(8-(i*3+k))*16 +: 16]) * longint'(b[(8-(k*3+j))*16 +: 16]);
`ifdef MATRIX_MULT_SAT_EN
               s = s + p;
`else
               s = (s + (p % 65536)) % 65536;
`endif
            end
            r[(8-(i*3+j))*16 +: 16] = (s > 65535) ? 16'hFFFF : 16'(s);
         end
      return r;
   endfunction

   task automatic run_op(input logic [143:0] a, input logic [143:0] b, input logic [143:0] exp, input string nm);
      int cyc, bcnt;
      A = a; B = b; start = 1;
      @(posedge clk); #1;
      start = 0; cyc = 1; bcnt = 0;
      while (!done && cyc < 100) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         cyc++;
      end
      check({nm, "_latency"}, 144'(cyc), 144'(28));
      check({nm, "_busy_cycles"}, 144'(bcnt), 144'(27));
      check({nm, "_result"}, Result, exp);
      @(posedge clk); #1;
      check({nm, "_done_pulse"}, 144'(done), 144'(0));
      check({nm, "_hold"}, Result, exp);
   endtask

   initial begin
      logic [143:0] a0, b0, exp0, r_at_done;
      int cyc, ndone, t1, t2;
      for (int e = 0; e < 9; e++) begin
         tv[0].a[(8-e)*16 +: 16] = (e % 4 == 0) ? 16'd1 : 16'd0;
         tv[0].b[(8-e)*16 +: 16] = 16'(e + 1);
         tv[0].exp[(8-e)*16 +: 16] = 16'(e + 1);
         tv[1].a[(8-e)*16 +: 16] = 16'd2;
         tv[1].b[(8-e)*16 +: 16] = 16'd3;
         tv[1].exp[(8-e)*16 +: 16] = 16'h0012;
      end
      tv[0].nm = "identity";
      tv[1].nm = "all2x3";
      tv[2].a = {16'h0100, 128'h0};
      tv[2].b = {16'h0100, 128'h0};
`ifdef MATRIX_MULT_SAT_EN
      tv[2].exp = {16'hFFFF, 128'h0};
`else
      tv[2].exp = {16'h0000, 128'h0};
`endif
      tv[2].nm = "overflow";

      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 144'(busy), 144'(0));
      check("reset_done", 144'(done), 144'(0));
      check("reset_result", Result, '0);
      rst = 0;
      @(posedge clk); #1;

      for (int t = 0; t < 3; t++) run_op(tv[t].a, tv[t].b, tv[t].exp, tv[t].nm);

      for (int t = 0; t < 6; t++) begin
         for (int e = 0; e < 9; e++) begin
            a0[e*16 +: 16] = (t < 3) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            b0[e*16 +: 16] = (t < 3) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         end
         run_op(a0, b0, model(a0, b0), $sformatf("random%0d", t));
      end

      // start pulses mid-operation and an operand change after latching
      for (int e = 0; e < 9; e++) begin
         a0[e*16 +: 16] = 16'($urandom);
         b0[e*16 +: 16] = 16'($urandom);
      end
      exp0 = model(a0, b0);
      A = a0; B = b0; start = 1;
      @(posedge clk); #1;
      start = 0; cyc = 1; ndone = 0; r_at_done = '0;
      while (cyc < 80) begin
         if (done) begin ndone++; r_at_done = Result; end
         start = (cyc == 5 || cyc == 20);
         if (cyc == 10) A = ~a0;
         @(posedge clk); #1;
         cyc++;
      end
      check("ignore_start_done_count", 144'(ndone), 144'(1));
      check("ignore_start_result", r_at_done, exp0);

      // reset in the middle of MAC
      A = a0; B = b0; start = 1;
      @(posedge clk); #1;
      start = 0; cyc = 1;
      while (cyc < 10) begin @(posedge clk); #1; cyc++; end
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      check("midrst_busy", 144'(busy), 144'(0));
      check("midrst_done", 144'(done), 144'(0));
      check("midrst_result", Result, '0);
      ndone = 0;
      repeat (40) begin if (done) ndone++; @(posedge clk); #1; end
      check("midrst_no_done", 144'(ndone), 144'(0));
      run_op(a0, b0, exp0, "after_rst");

      // reset wins over start
      rst = 1; start = 1;
      @(posedge clk); #1;
      check("rst_priority_busy", 144'(busy), 144'(0));
      rst = 0; start = 0;
      @(posedge clk); #1;

      // continuous start: restarts every N^3+2 cycles
      A = a0; B = b0; start = 1;
      cyc = 0; t1 = -1; t2 = -1;
      while (t2 < 0 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (done) begin if (t1 < 0) t1 = cyc; else t2 = cyc; end
      end
      start = 0;
      check("continuous_period", 144'(t2 - t1), 144'(29));
      check("continuous_result", Result, exp0);
      repeat (35) @(posedge clk);
      #1;

      // second instance N=2, W=8
      A2 = 32'h01020304; B2 = 32'h05060708; start2 = 1;
      @(posedge clk); #1;
      start2 = 0; cyc = 1;
      while (!done2 && cyc < 50) begin @(posedge clk); #1; cyc++; end
      check("n2_latency", 144'(cyc), 144'(9));
      check("n2_result", 144'(res2), 144'(32'h13162B32));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
